add32_pipe_stage: RTL and testbench
===================================

// Module: add32_pipe_stage
// PURPOSE
//  Registered valid/ready wrapper around the 32-bit Sklansky prefix adder.
//  - Captures operands, applies add/sub selection and feeds a, b, cin to the adder.
//  - Registers sum/cout together with status flags for the downstream consumer.
//  - Supplies the clocked pipeline stage the adder datapath lacks; adder stays combinational.
// PARAMETERS
//  PIPE_IN  1  1: input register stage S1 before adder; 0: adder fed directly from in_* ports
//  TAG_W    4  width of opaque sideband tag carried alongside each operation
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous active-high reset
//  in_valid   in   1      operation offered on in_*
//  in_ready   out  1      stage accepts operation this cycle
//  in_a       in   32     operand A
//  in_b       in   32     operand B
//  in_sub     in   1      0: A+B+cin; 1: A-B-borrow (borrow = in_cin)
//  in_cin     in   1      carry-in (add) / borrow-in (sub)
//  in_tag     in   TAG_W  sideband, returned unchanged on out_tag
//  out_valid  out  1      result held on out_*
//  out_ready  in   1      consumer takes result this cycle
//  out_sum    out  32     result
//  out_cout   out  1      adder carry-out (sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow of the raw sum
//  out_zero   out  1      out_sum == 0
//  out_neg    out  1      out_sum[31]
//  out_tag    out  TAG_W  tag of this result
//  busy       out  1      any stage holds a valid operation
// BEHAVIOUR
//  - Transfer: in on in_valid&in_ready; out on out_valid&out_ready. Accept/drain in same cycle allowed.
//  - Adder operands: b_eff = in_sub ? ~b : b; cin_eff = in_sub ? ~in_cin : in_cin.
//  - Flags (combinational from stage data, registered into S2):
//    ovf = (a[31]==b_eff[31]) & (sum[31]!=a[31]); zero/neg computed on final (post-sat) sum.
//  - Stages: S1 (PIPE_IN=1 only) holds a, b_eff, cin_eff, tag, s1_v. S2 holds sum, cout, flags, tag, s2_v.
//    - s2_adv = !s2_v | out_ready.
//    - in_ready = PIPE_IN ? (!s1_v | s2_adv) : s2_adv. No combinational in_valid->in_ready path.
//  - Occupancy FSM (PIPE_IN=1): EMPTY(s1_v=0,s2_v=0), HALF(exactly one set), FULL(both set).
//    - EMPTY -accept-> HALF.
//    - HALF: accept & drain keep HALF; accept w/o drain -> FULL (only if S2 held; S1 advances otherwise).
//    - HALF -drain-> EMPTY.
//    - FULL: out_ready -> S1 moves to S2, new accept allowed same cycle; !out_ready -> hold, in_ready=0.
//  - Latency: accept to out_valid = 2 cycles (PIPE_IN=1), 1 cycle (PIPE_IN=0). Throughput 1/cycle when out_ready=1.
//  - Stall: all S2 outputs stable while out_valid&!out_ready; S1 likewise frozen while blocked.
//  - Wrap-around: unsigned results wrap mod 2^32; cout reports the carry, and out_ovf reports signed overflow.
//  - Reset (async, any time, including mid-operation):
//    - s1_v=s2_v=0, out_valid=0, busy=0, in_ready=1 after release.
//    - out_sum=0, out_cout=0, out_ovf=0, out_zero=1, out_neg=0, out_tag=0.
//    - In-flight operations are discarded, not completed.
//  - in_* with in_valid=0 ignored; data registers load only on transfer (no toggling when idle).
// CONFIGURATION
//  ADD32_SAT_EN defined: signed saturation.
//    - When ovf=1, out_sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF.
//    - out_ovf still 1; out_cout is the raw adder carry.
//  ADD32_SAT_EN undefined: out_sum = raw adder sum (two's-complement wrap); no saturation logic built.
// TESTING
//  1 add: a=32'h0000_0005,b=32'h0000_0003,sub=0,cin=1 -> 2 cycles later sum=9,cout=0,ovf=0,zero=0
//  2 sub: a=5,b=5,sub=1,cin=0 -> sum=0,zero=1,cout=1; a=3,b=5 -> sum=32'hFFFF_FFFE,neg=1,cout=0
//  3 overflow: a=32'h7FFF_FFFF,b=1,add -> ovf=1; sum=32'h8000_0000 (no macro) / 32'h7FFF_FFFF (ADD32_SAT_EN)
//  4 backpressure: out_ready=0, stream 3 ops -> 2 held, in_ready=0 on 3rd, outputs stable; release -> in-order tags 0,1,2
//  5 reset mid-flight: FULL pipeline, pulse rst async between edges -> out_valid=0, out_zero=1, no stale result after release
//  6 throughput: out_ready=1, 16 back-to-back random ops -> one result per cycle, all match a+b_eff+cin_eff mod 2^32

Source files
------------

// File: rtl/add32_pipe_stage.sv
// add32_pipe_stage: valid/ready pipeline stage around a combinational 32-bit Sklansky prefix adder.
// Build macro ADD32_SAT_EN adds signed saturation of the result; default build wraps.
`default_nettype none

module add32_sklansky (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] pb;
    logic [31:0] g;
    logic [31:0] p;

    // Carry-in folded into bit 0 generate so g[i] ends up as the carry out of bit i.
    // Each level updates in place: the partner index always has the level bit clear.
    always_comb begin
        pb   = a ^ b;
        g    = a & b;
        p    = pb;
        g[0] = g[0] | (pb[0] & cin);
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i >> l) & 1) == 1) begin
                    g[5'(i)] = g[5'(i)] | (p[5'(i)] & g[5'(((i >> l) << l) - 1)]);
                    p[5'(i)] = p[5'(i)] & p[5'(((i >> l) << l) - 1)];
                end
            end
        end
    end

    assign sum  = pb ^ {g[30:0], cin};
    assign cout = g[31];
endmodule

module add32_pipe_stage #(
    parameter int PIPE_IN = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic             cin;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [31:0]      sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} occ_t;

    localparam res_t RES_RST = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0, tag: '0};

    op_t         in_op;
    op_t         s1_op;
    op_t         src_op;
    res_t        res;
    res_t        s2_res;
    occ_t        occ;
    logic        s1_v;
    logic        s2_v;
    logic        s1_nxt;
    logic        s2_nxt;
    logic        s2_adv;
    logic        accept;
    logic        src_v;
    logic [31:0] raw_sum;
    logic [31:0] fin_sum;
    logic        raw_cout;
    logic        ovf;

    // Subtraction is A + ~B + ~borrow, so the stored operand is already b_eff/cin_eff.
    assign in_op = '{a:   in_a,
                     b:   in_sub ? ~in_b : in_b,
                     cin: in_sub ? ~in_cin : in_cin,
                     tag: in_tag};

    assign s2_adv = !s2_v || out_ready;
    assign accept = in_valid && in_ready;

    generate
        if (PIPE_IN != 0) begin : g_pipe_in
            assign in_ready = (occ != FULL) || out_ready;
            assign src_v    = s1_v;
            assign src_op   = s1_op;
        end else begin : g_direct
            assign in_ready = s2_adv;
            assign src_v    = in_valid;
            assign src_op   = in_op;
        end
    endgenerate

    always_comb begin
        s2_nxt = s2_v;
        if (s2_adv)
            s2_nxt = src_v;
        if (PIPE_IN != 0)
            s1_nxt = accept || (s1_v && !s2_adv);
        else
            s1_nxt = 1'b0;
    end

    // Occupancy FSM; HALF covers either single stage being full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            occ  <= EMPTY;
        end else begin
            s1_v <= s1_nxt;
            s2_v <= s2_nxt;
            case ({s1_nxt, s2_nxt})
                2'b00:   occ <= EMPTY;
                2'b11:   occ <= FULL;
                default: occ <= HALF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_op <= '0;
        else if (PIPE_IN != 0 && accept)
            s1_op <= in_op;
    end

    add32_sklansky u_add (
        .a    (src_op.a),
        .b    (src_op.b),
        .cin  (src_op.cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    assign ovf = (src_op.a[31] == src_op.b[31]) && (raw_sum[31] != src_op.a[31]);

`ifdef ADD32_SAT_EN
    // Clamp toward the common operand sign on signed overflow.
    assign fin_sum = ovf ? (src_op.a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw_sum;
`else
    assign fin_sum = raw_sum;
`endif

    assign res = '{sum:  fin_sum,
                   cout: raw_cout,
                   ovf:  ovf,
                   zero: (fin_sum == 32'h0),
                   neg:  fin_sum[31],
                   tag:  src_op.tag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s2_res <= RES_RST;
        else if (s2_adv && src_v)
            s2_res <= res;
    end

    assign out_valid = s2_v;
    assign out_sum   = s2_res.sum;
    assign out_cout  = s2_res.cout;
    assign out_ovf   = s2_res.ovf;
    assign out_zero  = s2_res.zero;
    assign out_neg   = s2_res.neg;
    assign out_tag   = s2_res.tag;
    assign busy      = (occ != EMPTY);
endmodule

`default_nettype wire

// File: tb/tb_add32_pipe_stage.sv
// Self-checking bench for add32_pipe_stage (default PIPE_IN=1): vector table, hand sequences,
// and randomized streams scored against an arithmetic reference model.
module tb_add32_pipe_stage;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             in_sub;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    add32_pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } vec_t;

    int               checks = 0;
    int               failures = 0;
    exp_t             exp_q[$];
    logic [TAG_W-1:0] seen_tags[$];
    bit               t_in_hs;
    bit               t_out_hs;
    vec_t             vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: plain wide integer arithmetic, signed overflow by range test.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                   input logic cin, input logic [TAG_W-1:0] tag);
        exp_t        r;
        logic [31:0] be;
        logic        ce;
        longint      u;
        longint      s;
        be = sub ? ~b : b;
        ce = sub ? ~cin : cin;
        u  = longint'(a) + longint'(be) + longint'(ce);
        s  = longint'($signed(a)) + longint'($signed(be)) + longint'(ce);
        r.cout = u[32];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.sum  = u[31:0];
`ifdef ADD32_SAT_EN
        if (r.ovf) r.sum = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        r.zero = (r.sum == 32'h0);
        r.neg  = r.sum[31];
        r.tag  = tag;
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, input logic [TAG_W-1:0] tag);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_tag = tag; in_valid = 1'b1;
    endtask

    // One clock: score outputs and record handshakes mid-cycle, return just after the next edge.
    task automatic tick();
        exp_t act;
        t_in_hs  = 1'b0;
        t_out_hs = 1'b0;
        @(negedge clk);
        if (out_valid) begin
            chk("sb_result_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                act = '{out_sum, out_cout, out_ovf, out_zero, out_neg, out_tag};
                chk("sb_result", 64'(act), 64'(exp_q[0]));
                if (out_ready) begin
                    seen_tags.push_back(out_tag);
                    void'(exp_q.pop_front());
                    t_out_hs = 1'b1;
                end
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_sub, in_cin, in_tag));
            t_in_hs = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n, input int rdy_pct, input int vld_pct, input bit tput);
        int sent = 0, got = 0, cyc = 0, first = -1, last = -1, stalls = 0;
        bit have = 1'b0;
        while (got < n && cyc < 5000) begin
            if (!have && sent < n && int'($urandom_range(99)) < vld_pct) begin
                in_a   = rnd_word();
                in_b   = rnd_word();
                in_sub = 1'($urandom_range(1));
                in_cin = 1'($urandom_range(1));
                in_tag = TAG_W'(sent);
                have   = 1'b1;
            end
            in_valid  = have;
            out_ready = int'($urandom_range(99)) < rdy_pct;
            tick();
            if (t_out_hs) begin
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (t_in_hs) begin
                sent++;
                have = 1'b0;
            end else if (have) begin
                stalls++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_results", 64'(got), 64'(n));
        if (tput) begin
            chk("tput_first_latency", 64'(first), 64'(2));
            chk("tput_span", 64'(last - first), 64'(n - 1));
            chk("tput_in_stalls", 64'(stalls), 64'(0));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{32'h5, 32'h3, 1'b0, 1'b1, 32'h9, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h5, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h3, 32'h5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADD32_SAT_EN
        vecs[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; in_tag = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_zero", 64'(out_zero), 64'(1));
        chk("rst_out_sum", 64'(out_sum), 64'(0));
        chk("rst_flags", 64'({out_cout, out_ovf, out_neg}), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_busy", 64'(busy), 64'(0));

        // Directed vectors, one op at a time
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, TAG_W'(i));
            #1;
            chk("tbl_in_ready", 64'(in_ready), 64'(1));
            tick();
            in_valid = 1'b0;
            chk("tbl_busy", 64'(busy), 64'(1));
            lat = 1;
            while (!out_valid && lat < 8) begin
                tick();
                lat++;
            end
            chk("tbl_latency", 64'(lat), 64'(2));
            chk("tbl_sum", 64'(out_sum), 64'(vecs[i].sum));
            chk("tbl_cout", 64'(out_cout), 64'(vecs[i].cout));
            chk("tbl_ovf", 64'(out_ovf), 64'(vecs[i].ovf));
            chk("tbl_zero", 64'(out_zero), 64'(vecs[i].zero));
            chk("tbl_neg", 64'(out_neg), 64'(vecs[i].neg));
            chk("tbl_tag", 64'(out_tag), 64'(i));
            tick();
        end

        // Backpressure: two ops fill the pipe, third is refused, outputs hold
        seen_tags.delete();
        out_ready = 1'b0;
        drive(32'd1, 32'd2, 1'b0, 1'b0, 4'd0);
        #1 chk("bp_ready_op0", 64'(in_ready), 64'(1));
        tick();
        drive(32'd10, 32'd20, 1'b0, 1'b0, 4'd1);
        #1 chk("bp_ready_op1", 64'(in_ready), 64'(1));
        tick();
        drive(32'd100, 32'd200, 1'b1, 1'b0, 4'd2);
        #1;
        chk("bp_full_in_ready", 64'(in_ready), 64'(0));
        chk("bp_full_out_valid", 64'(out_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold_tag", 64'(out_tag), 64'(0));
            chk("bp_hold_sum", 64'(out_sum), 64'(3));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && (exp_q.size() != 0 || in_valid); k++) begin
            tick();
            if (t_in_hs) in_valid = 1'b0;
        end
        chk("bp_drain_count", 64'(seen_tags.size()), 64'(3));
        for (int k = 0; k < 3 && k < seen_tags.size(); k++)
            chk("bp_tag_order", 64'(seen_tags[k]), 64'(k));
        chk("bp_idle_busy", 64'(busy), 64'(0));

        // Async reset with a full pipe
        out_ready = 1'b0;
        drive(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 4'd5);
        tick();
        drive(32'd7, 32'd8, 1'b0, 1'b0, 4'd6);
        tick();
        in_valid = 1'b0;
        chk("mid_full_busy", 64'(busy), 64'(1));
        chk("mid_full_cout", 64'(out_cout), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_zero", 64'(out_zero), 64'(1));
        chk("mid_rst_out_cout", 64'(out_cout), 64'(0));
        chk("mid_rst_out_tag", 64'(out_tag), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        @(negedge clk); #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        // Idle inputs must be ignored and nothing stale may emerge
        for (int k = 0; k < 4; k++) begin
            in_a = $urandom(); in_b = $urandom(); in_tag = 4'($urandom_range(15));
            tick();
            chk("post_rst_no_out", 64'(out_valid), 64'(0));
            chk("post_rst_in_ready_idle", 64'(in_ready), 64'(1));
        end

        // Back-to-back throughput then randomized backpressure
        run_stream(16, 100, 100, 1'b1);
        run_stream(300, 60, 70, 1'b0);
        run_stream(100, 25, 100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
